// File: rtl/vc_input_buffer.sv
// vc_input_buffer
//   Per-input-port virtual-channel flit buffer. Each VC has its own circular FIFO and a
//   downstream credit counter. The buffer offers a request per VC to the allocation
//   arbiter. On a valid one-hot grant it pops that VC, emits the head flit one cycle later,
//   and returns one credit upstream.
//
//   Optional build macro: VCBUF_ERR_CHECK_EN
//     When it is defined, overflow_err_o becomes a sticky flag. It is set by any of:
//       - a write to a full VC,
//       - a credit return to a VC whose counter is already at its maximum,
//       - a nonzero grant with more than one bit set.
//     When it is undefined, overflow_err_o is tied low. Data-path behaviour is the same
//     in both builds.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   valid_i         incoming flit valid
//   flit_i          incoming flit
//   vc_id_i         target VC of the incoming flit
//   requests_o      per-VC request (the VC holds a flit and has a credit)
//   grants_i        one-hot grant from the arbiter
//   valid_o         outgoing flit valid (one-cycle pulse)
//   flit_o          outgoing flit (holds its value when valid_o is low)
//   vc_id_o         VC of the outgoing flit
//   credit_valid_i  downstream returned one credit
//   credit_vc_i     VC of the returned credit
//   credit_valid_o  one slot freed, credit sent upstream
//   credit_vc_o     VC of the freed slot
//   full_o          per-VC FIFO full
//   overflow_err_o  sticky error flag

module vc_input_buffer #(
  parameter int unsigned VC_NUM       = 4,
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned CREDIT_NUM   = 4,
  localparam int unsigned VcW         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic [VcW-1:0]        vc_id_i,
  output logic [VC_NUM-1:0]     requests_o,
  input  logic [VC_NUM-1:0]     grants_i,
  output logic                  valid_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic [VcW-1:0]        vc_id_o,
  input  logic                  credit_valid_i,
  input  logic [VcW-1:0]        credit_vc_i,
  output logic                  credit_valid_o,
  output logic [VcW-1:0]        credit_vc_o,
  output logic [VC_NUM-1:0]     full_o,
  output logic                  overflow_err_o
);

  localparam int unsigned PtrW  = $clog2(BUFFER_DEPTH);
  localparam int unsigned OccW  = PtrW + 1;
  localparam int unsigned CredW = $clog2(CREDIT_NUM + 1);
  localparam logic [OccW-1:0]  OccFull = OccW'(BUFFER_DEPTH);
  localparam logic [CredW-1:0] CredMax = CredW'(CREDIT_NUM);

  logic [FLIT_WIDTH-1:0] mem_q [VC_NUM][BUFFER_DEPTH];

  logic [PtrW-1:0]  wr_ptr_q [VC_NUM];
  logic [PtrW-1:0]  wr_ptr_d [VC_NUM];
  logic [PtrW-1:0]  rd_ptr_q [VC_NUM];
  logic [PtrW-1:0]  rd_ptr_d [VC_NUM];
  logic [OccW-1:0]  occ_q    [VC_NUM];
  logic [OccW-1:0]  occ_d    [VC_NUM];
  logic [CredW-1:0] credit_q [VC_NUM];
  logic [CredW-1:0] credit_d [VC_NUM];

  logic [VC_NUM-1:0] wr_en;
  logic [VC_NUM-1:0] pop_en;
  logic [VC_NUM-1:0] cred_in;
  logic              grant_onehot;
  logic              pop_any;
  logic [VcW-1:0]    pop_vc;

  logic                  valid_q;
  logic [FLIT_WIDTH-1:0] flit_q;
  logic [VcW-1:0]        vc_id_q;
  logic                  credit_valid_q;
  logic [VcW-1:0]        credit_vc_q;

  // Requests and full flags come only from registered state. A flit written in a cycle
  // cannot request until the next cycle.
  always_comb begin
    requests_o = '0;
    full_o     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      requests_o[v] = (occ_q[v] != '0) && (credit_q[v] != '0);
      full_o[v]     = (occ_q[v] == OccFull);
    end
  end

  // A grant with more than one bit set causes no pop.
  assign grant_onehot = ($countones(grants_i) == 1);
  assign pop_en       = grant_onehot ? (grants_i & requests_o) : '0;
  assign pop_any      = |pop_en;

  always_comb begin
    pop_vc = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (pop_en[v]) pop_vc = VcW'(v);
    end
  end

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      // The full check uses the pre-pop state, so a full VC rejects a write even when it
      // is popped in the same cycle.
      wr_en[v]    = valid_i && (vc_id_i == VcW'(v)) && !full_o[v];
      cred_in[v]  = credit_valid_i && (credit_vc_i == VcW'(v));
      wr_ptr_d[v] = wr_en[v]  ? wr_ptr_q[v] + PtrW'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = pop_en[v] ? rd_ptr_q[v] + PtrW'(1) : rd_ptr_q[v];

      occ_d[v] = occ_q[v];
      if (wr_en[v] && !pop_en[v]) begin
        occ_d[v] = occ_q[v] + OccW'(1);
      end else if (!wr_en[v] && pop_en[v]) begin
        occ_d[v] = occ_q[v] - OccW'(1);
      end

      // A pop needs a nonzero credit, so the decrement cannot underflow.
      credit_d[v] = credit_q[v];
      if (pop_en[v] && !cred_in[v]) begin
        credit_d[v] = credit_q[v] - CredW'(1);
      end else if (cred_in[v] && !pop_en[v] && (credit_q[v] != CredMax)) begin
        credit_d[v] = credit_q[v] + CredW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        occ_q[v]    <= '0;
        credit_q[v] <= CredMax;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        occ_q[v]    <= occ_d[v];
        credit_q[v] <= credit_d[v];
      end
    end
  end

  // Flit storage needs no reset: the pointers and occupancy counts decide validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= flit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      flit_q         <= '0;
      vc_id_q        <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      valid_q        <= pop_any;
      credit_valid_q <= pop_any;
      if (pop_any) begin
        flit_q      <= mem_q[pop_vc][rd_ptr_q[pop_vc]];
        vc_id_q     <= pop_vc;
        credit_vc_q <= pop_vc;
      end
    end
  end

  assign valid_o        = valid_q;
  assign flit_o         = flit_q;
  assign vc_id_o        = vc_id_q;
  assign credit_valid_o = credit_valid_q;
  assign credit_vc_o    = credit_vc_q;

`ifdef VCBUF_ERR_CHECK_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (valid_i && full_o[vc_id_i]) err_d = 1'b1;
    if (credit_valid_i && (credit_q[credit_vc_i] == CredMax)) err_d = 1'b1;
    if ($countones(grants_i) > 1) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign overflow_err_o = err_q;
`else
  assign overflow_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;

`ifdef VCBUF_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] flit_i;
  logic [1:0]  vc_id_i;
  logic [3:0]  requests_o;
  logic [3:0]  grants_i;
  logic        valid_o;
  logic [31:0] flit_o;
  logic [1:0]  vc_id_o;
  logic        credit_valid_i;
  logic [1:0]  credit_vc_i;
  logic        credit_valid_o;
  logic [1:0]  credit_vc_o;
  logic [3:0]  full_o;
  logic        overflow_err_o;

  int n_checks = 0;
  int n_errors = 0;

  vc_input_buffer #(
    .VC_NUM       (4),
    .BUFFER_DEPTH (4),
    .FLIT_WIDTH   (32),
    .CREDIT_NUM   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .flit_i         (flit_i),
    .vc_id_i        (vc_id_i),
    .requests_o     (requests_o),
    .grants_i       (grants_i),
    .valid_o        (valid_o),
    .flit_o         (flit_o),
    .vc_id_o        (vc_id_o),
    .credit_valid_i (credit_valid_i),
    .credit_vc_i    (credit_vc_i),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o),
    .full_o         (full_o),
    .overflow_err_o (overflow_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs. Outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic wv, input logic [31:0] wf, input logic [1:0] wvc,
                     input logic [3:0] g, input logic cv, input logic [1:0] cvc);
    valid_i        = wv;
    flit_i         = wf;
    vc_id_i        = wvc;
    grants_i       = g;
    credit_valid_i = cv;
    credit_vc_i    = cvc;
    @(posedge clk);
    #1;
    valid_i        = 1'b0;
    grants_i       = 4'b0000;
    credit_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] vc, input logic [31:0] f);
    cyc(1'b1, f, vc, 4'b0000, 1'b0, 2'd0);
  endtask

  task automatic gnt(input logic [3:0] g);
    cyc(1'b0, 32'h0, 2'd0, g, 1'b0, 2'd0);
  endtask

  task automatic cred(input logic [1:0] vc);
    cyc(1'b0, 32'h0, 2'd0, 4'b0000, 1'b1, vc);
  endtask

  initial begin
    rst            = 1'b1;
    valid_i        = 1'b0;
    flit_i         = '0;
    vc_id_i        = '0;
    grants_i       = '0;
    credit_valid_i = 1'b0;
    credit_vc_i    = '0;
    #12;
    check("rst_req",    32'(requests_o),     32'h0);
    check("rst_full",   32'(full_o),         32'h0);
    check("rst_valid",  32'(valid_o),        32'h0);
    check("rst_cvalid", 32'(credit_valid_o), 32'h0);
    check("rst_flit",   flit_o,              32'h0);
    check("rst_err",    32'(overflow_err_o), 32'h0);
    rst = 1'b0;

    // Two flits on VC2, popped back to back.
    wr(2'd2, 32'hA0);
    check("t2_req_after_w0", 32'(requests_o), 32'h4);
    wr(2'd2, 32'hA1);
    check("t2_req_after_w1", 32'(requests_o), 32'h4);
    gnt(4'b0100);
    check("t2_p0_valid",  32'(valid_o),        32'h1);
    check("t2_p0_flit",   flit_o,              32'hA0);
    check("t2_p0_vc",     32'(vc_id_o),        32'h2);
    check("t2_p0_cvalid", 32'(credit_valid_o), 32'h1);
    check("t2_p0_cvc",    32'(credit_vc_o),    32'h2);
    check("t2_p0_req",    32'(requests_o),     32'h4);
    gnt(4'b0100);
    check("t2_p1_valid", 32'(valid_o),     32'h1);
    check("t2_p1_flit",  flit_o,           32'hA1);
    check("t2_p1_cvc",   32'(credit_vc_o), 32'h2);
    check("t2_p1_req",   32'(requests_o),  32'h0);
    gnt(4'b0000);
    check("t2_idle_valid",  32'(valid_o),        32'h0);
    check("t2_idle_cvalid", 32'(credit_valid_o), 32'h0);
    check("t2_hold_flit",   flit_o,              32'hA1);
    check("t2_hold_vc",     32'(vc_id_o),        32'h2);
    cred(2'd2);
    cred(2'd2);
    check("t2_no_err", 32'(overflow_err_o), 32'h0);

    // VC0 overflow: the fifth write is dropped.
    for (int i = 0; i < 5; i++) begin
      wr(2'd0, 32'hB0 + 32'(i));
      if (i == 2) check("t3_not_full", 32'(full_o), 32'h0);
      if (i == 3) check("t3_full4", 32'(full_o), 32'h1);
    end
    check("t3_full5", 32'(full_o),         32'h1);
    check("t3_err",   32'(overflow_err_o), 32'(ErrEn));
    for (int i = 0; i < 4; i++) begin
      gnt(4'b0001);
      check("t3_pop_flit",  flit_o,       32'hB0 + 32'(i));
      check("t3_pop_valid", 32'(valid_o), 32'h1);
    end
    check("t3_empty_full", 32'(full_o),     32'h0);
    check("t3_empty_req",  32'(requests_o), 32'h0);
    for (int i = 0; i < 4; i++) cred(2'd0);

    // VC1 credit exhaustion.
    for (int i = 0; i < 4; i++) wr(2'd1, 32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      gnt(4'b0010);
      check("t4_pop_flit", flit_o, 32'hC0 + 32'(i));
    end
    wr(2'd1, 32'hC4);
    wr(2'd1, 32'hC5);
    check("t4_no_credit_req", 32'(requests_o), 32'h0);
    cred(2'd1);
    check("t4_credit_req", 32'(requests_o), 32'h2);
    gnt(4'b0010);
    check("t4_pop5_valid", 32'(valid_o),    32'h1);
    check("t4_pop5_flit",  flit_o,          32'hC4);
    check("t4_req_after",  32'(requests_o), 32'h0);
    gnt(4'b0010);
    check("t4_blocked_valid", 32'(valid_o), 32'h0);
    cred(2'd1);
    gnt(4'b0010);
    check("t4_drain_flit", flit_o, 32'hC5);

    // VC3: a write to a full VC in the same cycle as a pop, then a pop with a credit return.
    for (int i = 0; i < 4; i++) wr(2'd3, 32'hD0 + 32'(i));
    check("t5_full", 32'(full_o), 32'h8);
    cyc(1'b1, 32'hD4, 2'd3, 4'b1000, 1'b0, 2'd0);
    check("t5_wp_valid", 32'(valid_o), 32'h1);
    check("t5_wp_flit",  flit_o,       32'hD0);
    check("t5_wp_full",  32'(full_o),  32'h0);
    cyc(1'b0, 32'h0, 2'd0, 4'b1000, 1'b1, 2'd3);
    check("t5_pc_flit", flit_o, 32'hD1);
    gnt(4'b1000);
    check("t5_d2", flit_o, 32'hD2);
    gnt(4'b1000);
    check("t5_d3",        flit_o,          32'hD3);
    check("t5_empty_req", 32'(requests_o), 32'h0);
    wr(2'd3, 32'hE0);
    gnt(4'b1000);
    check("t5_last_credit_valid", 32'(valid_o), 32'h1);
    check("t5_last_credit_flit",  flit_o,       32'hE0);
    check("t5_req_end",           32'(requests_o), 32'h0);

    // Credit saturation on VC2 and a multi-bit grant.
    cred(2'd2);
    check("t6_sat_err", 32'(overflow_err_o), 32'(ErrEn));
    wr(2'd0, 32'h60);
    for (int i = 0; i < 4; i++) wr(2'd2, 32'hF0 + 32'(i));
    gnt(4'b0101);
    check("t6_multi_grant_valid", 32'(valid_o), 32'h0);
    check("t6_multi_grant_err",   32'(overflow_err_o), 32'(ErrEn));
    gnt(4'b0001);
    check("t6_g0", flit_o, 32'h60);
    for (int i = 0; i < 3; i++) begin
      gnt(4'b0100);
      check("t6_f", flit_o, 32'hF0 + 32'(i));
    end
    wr(2'd2, 32'hF4);
    gnt(4'b0100);
    check("t6_f3",      flit_o,          32'hF3);
    check("t6_sat_req", 32'(requests_o), 32'h0);
    cred(2'd2);
    gnt(4'b0100);
    check("t6_f4", flit_o, 32'hF4);

    // Wrap-around on VC0 with concurrent write, pop and credit return.
    wr(2'd0, 32'h100);
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), 2'd0, 4'b0001, 1'b1, 2'd0);
      check("t7_wrap_flit",  flit_o,       32'h100 + 32'(i - 1));
      check("t7_wrap_valid", 32'(valid_o), 32'h1);
    end
    cyc(1'b0, 32'h0, 2'd0, 4'b0001, 1'b1, 2'd0);
    check("t7_wrap_last", flit_o, 32'h109);

    // Asynchronous reset in the middle of a transfer.
    wr(2'd0, 32'h200);
    wr(2'd0, 32'h201);
    gnt(4'b0001);
    check("t8_pre_valid", 32'(valid_o), 32'h1);
    rst = 1'b1;
    #1;
    check("t8_rst_valid",  32'(valid_o),        32'h0);
    check("t8_rst_flit",   flit_o,              32'h0);
    check("t8_rst_vc",     32'(vc_id_o),        32'h0);
    check("t8_rst_cvalid", 32'(credit_valid_o), 32'h0);
    check("t8_rst_cvc",    32'(credit_vc_o),    32'h0);
    check("t8_rst_req",    32'(requests_o),     32'h0);
    check("t8_rst_full",   32'(full_o),         32'h0);
    check("t8_rst_err",    32'(overflow_err_o), 32'h0);
    #2;
    rst = 1'b0;
    gnt(4'b0001);
    check("t8_post_req",   32'(requests_o), 32'h0);
    check("t8_post_valid", 32'(valid_o),    32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
